// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: owns the single write port of the 32x32 register bank.
// Merges the pipeline writeback stream (never stalled, always wins) with
// long-latency unit results that queue in a small FIFO until the port is free.
// A writeback to R invalidates any older queued result for R, so the younger
// value is never overwritten by a stale one.
// Optional feature macro: REGWR_QUERY_EN adds a combinational forwarding query
// port (qReg/qHit/qData) for decode.
module regbank_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wbValid,
    input  logic [4:0]    wbReg,
    input  logic [31:0]   wbData,
    input  logic          llValid,
    output logic          llReady,
    input  logic [4:0]    llReg,
    input  logic [31:0]   llData,
`ifdef REGWR_QUERY_EN
    input  logic [4:0]    qReg,
    output logic          qHit,
    output logic [31:0]   qData,
`endif
    output logic [4:0]    selWriteReg,
    output logic [31:0]   WriteData,
    output logic          enWriteReg,
    output logic [AW:0]   pendCount
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [4:0]  fifoRegQ   [DEPTH];
    logic [31:0] fifoDataQ  [DEPTH];
    logic        fifoValidQ [DEPTH];
    logic [AW-1:0] wrPtrQ;
    logic [AW-1:0] rdPtrQ;
    logic [AW:0]   countQ;
    logic [AW:0]   countD;

    logic        enWriteQ,  enWriteD;
    logic [4:0]  selQ,      selD;
    logic [31:0] dataQ,     dataD;

    logic wbAccept;
    logic push;
    logic pop;

    // A writeback to r0 is no request at all; a result for r0 is handshaken but dropped.
    assign llReady  = (countQ != FULL_COUNT);
    assign wbAccept = wbValid && (wbReg != 5'd0);
    assign push     = llValid && llReady && (llReg != 5'd0);
    assign pop      = !wbAccept && (countQ != '0);

    assign enWriteReg  = enWriteQ;
    assign selWriteReg = selQ;
    assign WriteData   = dataQ;
    assign pendCount   = countQ;

    // Occupancy tracks push/pop independently; a simultaneous pair leaves it unchanged.
    always_comb begin
        countD = countQ;
        case ({push, pop})
            2'b10:   countD = countQ + 1'b1;
            2'b01:   countD = countQ - 1'b1;
            default: countD = countQ;
        endcase
    end

    // FIFO storage: kill matching older entries on a writeback, then pop/push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifoRegQ[i]   <= '0;
                fifoDataQ[i]  <= '0;
                fifoValidQ[i] <= 1'b0;
            end
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (wbAccept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifoRegQ[i] == wbReg) begin
                        fifoValidQ[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                fifoValidQ[rdPtrQ] <= 1'b0;
                rdPtrQ             <= rdPtrQ + 1'b1;
            end
            if (push) begin
                fifoRegQ[wrPtrQ]   <= llReg;
                fifoDataQ[wrPtrQ]  <= llData;
                fifoValidQ[wrPtrQ] <= 1'b1;
                wrPtrQ             <= wrPtrQ + 1'b1;
            end
            countQ <= countD;
        end
    end

    // Pick the next bank write: writeback first, else the FIFO head if still live.
    always_comb begin
        enWriteD = 1'b0;
        selD     = selQ;
        dataD    = dataQ;
        if (wbAccept) begin
            enWriteD = 1'b1;
            selD     = wbReg;
            dataD    = wbData;
        end else if (pop && fifoValidQ[rdPtrQ]) begin
            enWriteD = 1'b1;
            selD     = fifoRegQ[rdPtrQ];
            dataD    = fifoDataQ[rdPtrQ];
        end
    end

    // Registered bank write port; reset drops any in-flight write immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enWriteQ <= 1'b0;
            selQ     <= '0;
            dataQ    <= '0;
        end else begin
            enWriteQ <= enWriteD;
            selQ     <= selD;
            dataQ    <= dataD;
        end
    end

`ifdef REGWR_QUERY_EN
    // Forwarding lookup: scan queued entries oldest to newest so the newest match
    // wins, then let the registered output override everything.
    always_comb begin
        logic [AW-1:0] idx;
        qHit  = 1'b0;
        qData = '0;
        idx   = '0;
        if (qReg != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = rdPtrQ + AW'(k);
                if ((k < int'(countQ)) && fifoValidQ[idx] && (fifoRegQ[idx] == qReg)) begin
                    qHit  = 1'b1;
                    qData = fifoDataQ[idx];
                end
            end
            if (enWriteQ && (selQ == qReg)) begin
                qHit  = 1'b1;
                qData = dataQ;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed checks of the register-bank write arbiter.
// Inputs change just after each falling edge; outputs are observed on the
// following falling edge, i.e. after exactly one rising edge.
module tb_regbank_write_arbiter;

    logic        clock;
    logic        reset_n;
    logic        wbValid;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        llValid;
    logic        llReady;
    logic [4:0]  llReg;
    logic [31:0] llData;
    logic [4:0]  selWriteReg;
    logic [31:0] WriteData;
    logic        enWriteReg;
    logic [2:0]  pendCount;
`ifdef REGWR_QUERY_EN
    logic [4:0]  qReg;
    logic        qHit;
    logic [31:0] qData;
`endif

    int errors = 0;
    int checks = 0;

    regbank_write_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wbValid     (wbValid),
        .wbReg       (wbReg),
        .wbData      (wbData),
        .llValid     (llValid),
        .llReady     (llReady),
        .llReg       (llReg),
        .llData      (llData),
`ifdef REGWR_QUERY_EN
        .qReg        (qReg),
        .qHit        (qHit),
        .qData       (qData),
`endif
        .selWriteReg (selWriteReg),
        .WriteData   (WriteData),
        .enWriteReg  (enWriteReg),
        .pendCount   (pendCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        wbValid = wv;
        wbReg   = wr;
        wbData  = wd;
        llValid = lv;
        llReg   = lr;
        llData  = ld;
    endtask

    task automatic stepCycle();
        @(negedge clock);
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [4:0] sel,
                              input logic [31:0] data, input logic [2:0] pend);
        checkOutput({tag, ".en"},   32'(enWriteReg),  32'(en));
        checkOutput({tag, ".sel"},  32'(selWriteReg), 32'(sel));
        checkOutput({tag, ".data"}, WriteData,        data);
        checkOutput({tag, ".pend"}, 32'(pendCount),   32'(pend));
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef REGWR_QUERY_EN
        qReg = 5'd0;
`endif
        #3;
        checkWrite("reset", 1'b0, 5'd0, 32'h0, 3'd0);
        checkOutput("reset.llReady", 32'(llReady), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // WB only
        applyStimulus(1'b1, 5'd2, 32'd25, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("wb_r2", 1'b1, 5'd2, 32'd25, 3'd0);
        applyStimulus(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("wb_r0", 1'b0, 5'd2, 32'd25, 3'd0);

        // LL only: second push coincides with the first pop
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA);
        stepCycle();
        checkWrite("ll_push5", 1'b0, 5'd2, 32'd25, 3'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hBBBB);
        stepCycle();
        checkWrite("ll_write5", 1'b1, 5'd5, 32'hAAAA, 3'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("ll_write6", 1'b1, 5'd6, 32'hBBBB, 3'd0);
        stepCycle();
        checkWrite("ll_idle", 1'b0, 5'd6, 32'hBBBB, 3'd0);

        // Priority and full: WB busy while four results queue
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h50 + 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            stepCycle();
            checkWrite("full_fill", 1'b1, 5'd1, 32'h50 + 32'(i), 3'(i + 1));
        end
        checkOutput("full.llReady", 32'(llReady), 32'd0);
        applyStimulus(1'b1, 5'd1, 32'h60, 1'b1, 5'd14, 32'h104);
        stepCycle();
        checkWrite("full_hold", 1'b1, 5'd1, 32'h60, 3'd4);
        checkOutput("full_hold.llReady", 32'(llReady), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkWrite("full_drain", 1'b1, 5'(10 + i), 32'h100 + 32'(i), 3'(3 - i));
        end
        checkOutput("drain.llReady", 32'(llReady), 32'd1);

        // Kill: younger WB to r7 invalidates the queued r7 result
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd7, 32'h11);
        stepCycle();
        checkWrite("kill_push", 1'b1, 5'd3, 32'h55, 3'd1);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("kill_wb", 1'b1, 5'd7, 32'h22, 3'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("kill_pop", 1'b0, 5'd7, 32'h22, 3'd0);

        // Same-cycle WB and LL push to r8: the pushed entry survives
        applyStimulus(1'b1, 5'd8, 32'h1, 1'b1, 5'd8, 32'h2);
        stepCycle();
        checkWrite("same_wb", 1'b1, 5'd8, 32'h1, 3'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("same_ll", 1'b1, 5'd8, 32'h2, 3'd0);

        // LL result for r0 handshakes but queues nothing
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        stepCycle();
        checkWrite("ll_r0", 1'b0, 5'd8, 32'h2, 3'd0);

`ifdef REGWR_QUERY_EN
        // Forwarding query: newest queued r9 wins
        applyStimulus(1'b1, 5'd1, 32'h70, 1'b1, 5'd9, 32'h33);
        stepCycle();
        applyStimulus(1'b1, 5'd1, 32'h71, 1'b1, 5'd9, 32'h44);
        stepCycle();
        applyStimulus(1'b1, 5'd1, 32'h72, 1'b0, 5'd0, 32'h0);
        qReg = 5'd9;
        #1;
        checkOutput("q9.hit", 32'(qHit), 32'd1);
        checkOutput("q9.data", qData, 32'h44);
        qReg = 5'd0;
        #1;
        checkOutput("q0.hit", 32'(qHit), 32'd0);
        checkOutput("q0.data", qData, 32'h0);
        qReg = 5'd1;
        #1;
        checkOutput("q1.hit", 32'(qHit), 32'd1);
        checkOutput("q1.data", qData, 32'h71);
        qReg = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("q_drain.pend", 32'(pendCount), 32'd0);
`endif

        // Reset mid-drain
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h90, 1'b1, 5'(20 + i), 32'h200 + 32'(i));
            stepCycle();
        end
        checkOutput("rst_fill.pend", 32'(pendCount), 32'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepCycle();
        checkWrite("rst_drain", 1'b1, 5'd20, 32'h200, 3'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkWrite("rst_async", 1'b0, 5'd0, 32'h0, 3'd0);
        checkOutput("rst_async.llReady", 32'(llReady), 32'd1);
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        checkWrite("rst_after1", 1'b0, 5'd0, 32'h0, 3'd0);
        stepCycle();
        checkWrite("rst_after2", 1'b0, 5'd0, 32'h0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
